// File: rtl/aexm_intsched_pkg.sv
// Shared types and defaults for the AEXM interrupt scheduler.
package aexm_intsched_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StWait    = 2'd1,
    StInject  = 2'd2,
    StService = 2'd3
  } state_e;

  localparam logic [31:0] VecBaseDefault  = 32'h0000_0010;
  localparam int unsigned VecShiftDefault = 3;

endpackage

// File: rtl/aexm_prio_enc.sv
// Lowest-index-first priority encoder: index of the lowest set request plus valid.
module aexm_prio_enc #(
  parameter int unsigned N    = 8,
  parameter int unsigned IdxW = 4
) (
  input  logic [N-1:0]    req_i,
  output logic [IdxW-1:0] idx_o,
  output logic            valid_o
);

  // Scan high to low so the lowest set index is written last.
  always_comb begin
    idx_o   = '0;
    valid_o = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o   = IdxW'(i);
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aexm_intsched.sv
// AEXM interrupt scheduler: arbitrates sources and injects at a safe decode boundary.
// Define AEXM_INTSCHED_EDGE_EN for rising-edge sticky pending instead of level requests.
module aexm_intsched
  import aexm_intsched_pkg::*;
#(
  parameter int unsigned NSRC      = 8,
  parameter int unsigned HOLDOFF   = 2,
  parameter logic [31:0] VEC_BASE  = VecBaseDefault,
  parameter int unsigned VEC_SHIFT = VecShiftDefault
) (
  input  logic            gclk,
  input  logic            grst,
  input  logic            d_en,
  input  logic            x_en,
  input  logic [NSRC-1:0] irq_req,
  input  logic            dSKIP,
  input  logic            xSKIP,
  input  logic            d_brimm,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  input  logic            gie_set,
  input  logic            rti_done,
  output logic            cpu_interrupt,
  output logic [31:0]     int_vector,
  output logic            int_active,
  output logic [3:0]      int_src,
  output logic [NSRC-1:0] irq_mask,
  output logic            gie
);

  localparam int unsigned CntW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

  state_e          state_q;
  logic            cpu_interrupt_q, int_active_q, gie_q;
  logic [31:0]     int_vector_q;
  logic [3:0]      int_src_q;
  logic [NSRC-1:0] irq_mask_q;
  logic [CntW-1:0] cnt_q;

  logic [NSRC-1:0] src_lvl, pend;
  logic [3:0]      win_idx;
  logic            win_valid;
  logic            safe;
  logic [31:0]     vec;

  logic unused_x_en;
  assign unused_x_en = x_en;

`ifdef AEXM_INTSCHED_EDGE_EN
  logic [NSRC-1:0] irq_d_q, sticky_q, sticky_d, edge_det, svc_clr;

  assign edge_det = irq_req & ~irq_d_q;
  assign svc_clr  = (state_q == StInject && d_en) ? (NSRC'(1) << int_src_q) : '0;
  // A fresh edge beats the service clear on the same cycle.
  assign sticky_d = (sticky_q & ~svc_clr) | edge_det;
  assign src_lvl  = sticky_q | edge_det;

  always_ff @(posedge gclk) begin
    if (grst) begin
      irq_d_q  <= '0;
      sticky_q <= '0;
    end else begin
      irq_d_q  <= irq_req;
      sticky_q <= sticky_d;
    end
  end
`else
  assign src_lvl = irq_req;
`endif

  assign pend = src_lvl & irq_mask_q & {NSRC{gie_q}};

  aexm_prio_enc #(
    .N   (NSRC),
    .IdxW(4)
  ) u_prio_enc (
    .req_i  (pend),
    .idx_o  (win_idx),
    .valid_o(win_valid)
  );

  assign safe = (cnt_q == '0) && !dSKIP && !xSKIP && !d_brimm;
  assign vec  = VEC_BASE + (32'(int_src_q) << VEC_SHIFT);

  // Holdoff after a branch/IMM decode; only advances with decode.
  always_ff @(posedge gclk) begin
    if (grst) begin
      cnt_q <= '0;
    end else if (d_en && (d_brimm || dSKIP)) begin
      cnt_q <= CntW'(HOLDOFF);
    end else if (d_en && cnt_q != '0) begin
      cnt_q <= cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge gclk) begin
    if (grst) begin
      state_q         <= StIdle;
      cpu_interrupt_q <= 1'b0;
      int_vector_q    <= '0;
      int_active_q    <= 1'b0;
      int_src_q       <= '0;
      irq_mask_q      <= '0;
      gie_q           <= 1'b0;
    end else begin
      if (mask_we) irq_mask_q <= mask_wd;
      if (gie_set) gie_q <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            int_src_q <= win_idx;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (d_en && safe) begin
            cpu_interrupt_q <= 1'b1;
            int_vector_q    <= vec;
            state_q         <= StInject;
          end
        end
        StInject: begin
          if (d_en) begin
            cpu_interrupt_q <= 1'b0;
            int_vector_q    <= '0;
            gie_q           <= 1'b0;
            int_active_q    <= 1'b1;
            state_q         <= StService;
          end
        end
        StService: begin
          if (rti_done) begin
            gie_q        <= 1'b1;
            int_active_q <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_interrupt = cpu_interrupt_q;
  assign int_vector    = int_vector_q;
  assign int_active    = int_active_q;
  assign int_src       = int_src_q;
  assign irq_mask      = irq_mask_q;
  assign gie           = gie_q;

endmodule

// File: tb/tb_aexm_intsched.sv
// Self-checking bench for aexm_intsched: scoreboard of expected injections plus direct checks.
module tb_aexm_intsched;

  logic        gclk = 1'b0;
  logic        grst = 1'b1;
  logic        d_en = 1'b1, x_en = 1'b1, dSKIP = 1'b0, xSKIP = 1'b0, d_brimm = 1'b0;
  logic        mask_we = 1'b0, gie_set = 1'b0, rti_done = 1'b0;
  logic [7:0]  irq_req = '0, mask_wd = '0;
  logic        cpu_interrupt, int_active, gie;
  logic [31:0] int_vector;
  logic [3:0]  int_src;
  logic [7:0]  irq_mask;

  aexm_intsched #(
    .NSRC     (8),
    .HOLDOFF  (2),
    .VEC_BASE (32'h0000_0010),
    .VEC_SHIFT(3)
  ) dut (
    .gclk         (gclk),
    .grst         (grst),
    .d_en         (d_en),
    .x_en         (x_en),
    .irq_req      (irq_req),
    .dSKIP        (dSKIP),
    .xSKIP        (xSKIP),
    .d_brimm      (d_brimm),
    .mask_we      (mask_we),
    .mask_wd      (mask_wd),
    .gie_set      (gie_set),
    .rti_done     (rti_done),
    .cpu_interrupt(cpu_interrupt),
    .int_vector   (int_vector),
    .int_active   (int_active),
    .int_src      (int_src),
    .irq_mask     (irq_mask),
    .gie          (gie)
  );

  always #5 gclk = ~gclk;

  typedef struct packed {
    logic [3:0]  src;
    logic [31:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs are driven and outputs sampled on the falling edge.
  task automatic step();
    @(negedge gclk);
  endtask

  task automatic push_exp(input logic [3:0] src, input logic [31:0] vec);
    exp_t e;
    e.src = src;
    e.vec = vec;
    sb_q.push_back(e);
  endtask

  task automatic wait_inject(input string tag, output int lat);
    exp_t e;
    lat = 0;
    while (!cpu_interrupt && lat < 20) begin
      step();
      lat++;
    end
    check({tag, "_seen"}, cpu_interrupt, 1);
    if (sb_q.size() == 0) begin
      check({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_src"}, int_src, e.src);
      check({tag, "_vec"}, int_vector, e.vec);
    end
  endtask

  task automatic do_rti(input string tag);
    rti_done = 1'b1;
    step();
    rti_done = 1'b0;
    check({tag, "_active_clr"}, int_active, 0);
    check({tag, "_gie_set"}, gie, 1);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_cpu_int"}, cpu_interrupt, 0);
    check({tag, "_vector"}, int_vector, 0);
    check({tag, "_active"}, int_active, 0);
    check({tag, "_src"}, int_src, 0);
    check({tag, "_mask"}, irq_mask, 0);
    check({tag, "_gie"}, gie, 0);
  endtask

  initial begin
    int lat;
    int seen;

    step();
    step();
    check_reset("rst");
    grst = 1'b0;

    mask_we = 1'b1;
    mask_wd = 8'hFF;
    gie_set = 1'b1;
    step();
    mask_we = 1'b0;
    gie_set = 1'b0;
    check("setup_mask", irq_mask, 8'hFF);
    check("setup_gie", gie, 1);

    // Basic injection: two-cycle latency, single-cycle pulse.
    irq_req = 8'h20;
    push_exp(4'd5, 32'h38);
    wait_inject("basic", lat);
    check("basic_latency", lat, 2);
    irq_req = 8'h00;
    step();
    check("basic_pulse_end", cpu_interrupt, 0);
    check("basic_vec_zero", int_vector, 0);
    check("basic_gie_clr", gie, 0);
    check("basic_active", int_active, 1);
    do_rti("basic_rti");

    // Priority: source 1 before source 7.
    irq_req = 8'h82;
    push_exp(4'd1, 32'h18);
    push_exp(4'd7, 32'h48);
    wait_inject("prio_first", lat);
    irq_req = 8'h80;
    step();
    do_rti("prio_rti1");
    wait_inject("prio_second", lat);
    irq_req = 8'h00;
    step();
    do_rti("prio_rti2");

    // Holdoff: IMM decode on the same cycle the request rises.
    irq_req = 8'h01;
    d_brimm = 1'b1;
    push_exp(4'd0, 32'h10);
    step();
    d_brimm = 1'b0;
    wait_inject("holdoff", lat);
    check("holdoff_latency", lat + 1, 4);
    irq_req = 8'h00;
    step();
    do_rti("holdoff_rti");

    // Stall in INJECT, then release with gie_set on the same cycle.
    irq_req = 8'h04;
    push_exp(4'd2, 32'h20);
    wait_inject("stall", lat);
    d_en = 1'b0;
    irq_req = 8'h00;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_cpu_hold", cpu_interrupt, 1);
      check("stall_vec_hold", int_vector, 32'h20);
    end
    d_en = 1'b1;
    gie_set = 1'b1;
    step();
    gie_set = 1'b0;
    check("stall_release", cpu_interrupt, 0);
    check("stall_active", int_active, 1);
    check("stall_gie_clear_wins", gie, 0);
    do_rti("stall_rti");

`ifdef AEXM_INTSCHED_EDGE_EN
    // Edge arriving during SERVICE is kept and served after return.
    irq_req = 8'h01;
    push_exp(4'd0, 32'h10);
    push_exp(4'd3, 32'h28);
    wait_inject("edge_first", lat);
    irq_req = 8'h00;
    step();
    irq_req = 8'h08;
    step();
    irq_req = 8'h00;
    step();
    check("edge_in_service", int_active, 1);
    do_rti("edge_rti1");
    wait_inject("edge_second", lat);
    step();
    do_rti("edge_rti2");
`endif

    // Masked requests never inject.
    mask_we = 1'b1;
    mask_wd = 8'h00;
    step();
    mask_we = 1'b0;
    irq_req = 8'hFF;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (cpu_interrupt) seen++;
    end
    check("mask_no_inj", seen, 0);

    // Unmask, enter SERVICE, then reset.
    irq_req = 8'h02;
`ifdef AEXM_INTSCHED_EDGE_EN
    push_exp(4'd0, 32'h10);
`else
    push_exp(4'd1, 32'h18);
`endif
    mask_we = 1'b1;
    mask_wd = 8'hFF;
    step();
    mask_we = 1'b0;
    wait_inject("unmask", lat);
    step();
    check("svc_before_rst", int_active, 1);
    grst = 1'b1;
    step();
    check_reset("rst_svc");
    grst = 1'b0;
    irq_req = 8'h00;
    step();

    check("sb_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
